// File: rtl/frame_pingpong_ctrl.sv
// Ping-pong frame steering between the camera write port and a two-bank frame buffer.
// Optional macro PP_DROP_CNT_EN enables the saturating dropped-frame counter.
module frame_pingpong_ctrl #(
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wData,
    input  logic              rd_frame_start,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_wAddr,
    output logic [DATA_W-1:0] mem_wData,
    output logic              rd_bank,
    output logic              frame_pending,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2,
        S_SKIP    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    state_t              state_q, state_d;
    logic                vs_meta_q, vs_sync_q, vs_prev_q;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic                pending_q, pending_d;
    logic                mem_we_q;
    logic [ADDR_W:0]     mem_wAddr_q;
    logic [DATA_W-1:0]   mem_wData_q;

    logic fs_s;
    logic fwd_s;
    logic pend_eff_s;
    logic drop_inc_s;

    assign fs_s       = vs_prev_q & ~vs_sync_q;
    assign fwd_s      = (state_q == S_CAPTURE) && we && (wAddr <= LAST_ADDR);
    // A handover in the same cycle as fs frees the pending slot first
    assign pend_eff_s = pending_q & ~rd_frame_start;

    // Next-state, bank steering and handover decisions
    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        pending_d  = pending_q;
        drop_inc_s = 1'b0;

        if (rd_frame_start && pending_q) begin
            rd_bank_d = wr_bank_q;
            pending_d = 1'b0;
        end else begin
            rd_bank_d = rd_bank_q;
        end

        case (state_q)
            S_IDLE: begin
                if (fs_s) begin
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                // Completion beats a coincident fs; a bare fs restarts on the same bank
                if (fwd_s && (wAddr == LAST_ADDR)) begin
                    pending_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_DONE, S_SKIP: begin
                if (fs_s) begin
                    if (!pend_eff_s) begin
                        wr_bank_d = ~wr_bank_q;
                        state_d   = S_CAPTURE;
                    end else begin
                        drop_inc_s = 1'b1;
                        state_d    = S_SKIP;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, synchroniser and registered write-port outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            vs_meta_q   <= 1'b0;
            vs_sync_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            wr_bank_q   <= 1'b1;
            rd_bank_q   <= 1'b0;
            pending_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wAddr_q <= '0;
            mem_wData_q <= '0;
        end else begin
            state_q   <= state_d;
            vs_meta_q <= vsync;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            pending_q <= pending_d;
            mem_we_q  <= fwd_s;
            if (we) begin
                mem_wAddr_q <= {wr_bank_q, wAddr};
                mem_wData_q <= wData;
            end
        end
    end

`ifdef PP_DROP_CNT_EN
    logic [7:0] drop_q;

    // Saturating count of camera frames discarded while the display lagged
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= 8'd0;
        end else if (drop_inc_s && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    logic unused_drop_s;
    assign unused_drop_s = drop_inc_s;
    assign drop_cnt      = 8'd0;
`endif

    assign mem_we        = mem_we_q;
    assign mem_wAddr     = mem_wAddr_q;
    assign mem_wData     = mem_wData_q;
    assign rd_bank       = rd_bank_q;
    assign frame_pending = pending_q;

endmodule

// File: tb/tb_frame_pingpong_ctrl.sv
// Directed self-checking bench for frame_pingpong_ctrl (honours PP_DROP_CNT_EN).
module tb_frame_pingpong_ctrl;

`ifdef PP_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        vsync;
    logic        we;
    logic [16:0] wAddr;
    logic [15:0] wData;
    logic        rd_frame_start;
    logic        mem_we;
    logic [17:0] mem_wAddr;
    logic [15:0] mem_wData;
    logic        rd_bank;
    logic        frame_pending;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_drop = 0;

    frame_pingpong_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .vsync          (vsync),
        .we             (we),
        .wAddr          (wAddr),
        .wData          (wData),
        .rd_frame_start (rd_frame_start),
        .mem_we         (mem_we),
        .mem_wAddr      (mem_wAddr),
        .mem_wData      (mem_wData),
        .rd_bank        (rd_bank),
        .frame_pending  (frame_pending),
        .drop_cnt       (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d, input logic exp_we,
                      input logic exp_bank, input string tag);
        logic [17:0] ea;
        ea    = {exp_bank, a[16:0]};
        we    = 1'b1;
        wAddr = a[16:0];
        wData = d;
        cyc();
        we    = 1'b0;
        chk({tag, "_we"},   32'(mem_we),    32'(exp_we));
        chk({tag, "_addr"}, 32'(mem_wAddr), 32'(ea));
        chk({tag, "_data"}, 32'(mem_wData), 32'(d));
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        repeat (3) cyc();
        vsync = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic handover();
        rd_frame_start = 1'b1;
        cyc();
        rd_frame_start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_we"},  32'(mem_we),        32'd0);
        chk({tag, "_addr"},    32'(mem_wAddr),     32'd0);
        chk({tag, "_data"},    32'(mem_wData),     32'd0);
        chk({tag, "_rd_bank"}, 32'(rd_bank),       32'd0);
        chk({tag, "_pending"}, 32'(frame_pending), 32'd0);
        chk({tag, "_drop"},    32'(drop_cnt),      32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        vsync          = 1'b0;
        we             = 1'b0;
        wAddr          = 17'd0;
        wData          = 16'd0;
        rd_frame_start = 1'b0;
        repeat (2) cyc();
        chk_reset_outputs("rst");
        reset = 1'b0;

        // IDLE: address/data still latched, write suppressed, bank 1 selected
        wr(5, 16'h1234, 1'b0, 1'b1, "idle_wr");

        // First frame into bank 1 (head and tail of the frame)
        frame_start();
        for (int a = 0; a < 64; a++) wr(a, a[15:0], 1'b1, 1'b1, "f1_head");
        for (int a = 76736; a < 76799; a++) wr(a, a[15:0], 1'b1, 1'b1, "f1_tail");
        chk("f1_pending_before_last", 32'(frame_pending), 32'd0);
        wr(76799, 16'h2BFF, 1'b1, 1'b1, "f1_last");
        chk("f1_pending_on_last", 32'(frame_pending), 32'd1);
        chk("f1_rd_bank", 32'(rd_bank), 32'd0);
        wr(10, 16'h0A0A, 1'b0, 1'b1, "done_wr");

        // Handover to display, then a no-op pulse
        handover();
        chk("ho1_rd_bank", 32'(rd_bank), 32'd1);
        chk("ho1_pending", 32'(frame_pending), 32'd0);
        handover();
        chk("ho_noop_rd_bank", 32'(rd_bank), 32'd1);

        // Second frame into bank 0
        frame_start();
        wr(0, 16'hA5A5, 1'b1, 1'b0, "f2_first");
        wr(76799, 16'h5A5A, 1'b1, 1'b0, "f2_last");
        chk("f2_pending", 32'(frame_pending), 32'd1);

        // No handover: next camera frame is dropped
        frame_start();
        if (DROP_EN) exp_drop = 1;
        chk("drop1_cnt", 32'(drop_cnt), 32'(exp_drop));
        wr(0, 16'h1111, 1'b0, 1'b0, "skip_wr0");
        wr(76799, 16'h2222, 1'b0, 1'b0, "skip_wrlast");
        chk("skip_pending", 32'(frame_pending), 32'd1);
        chk("skip_rd_bank", 32'(rd_bank), 32'd1);
        handover();
        chk("ho2_rd_bank", 32'(rd_bank), 32'd0);
        chk("ho2_pending", 32'(frame_pending), 32'd0);
        frame_start();
        wr(3, 16'h3333, 1'b1, 1'b1, "f4_first");
        wr(76799, 16'h4444, 1'b1, 1'b1, "f4_last");
        chk("f4_pending", 32'(frame_pending), 32'd1);
        chk("f4_drop", 32'(drop_cnt), 32'(exp_drop));

        // Handover coincident with fs: handover wins, no drop, bank toggles
        vsync = 1'b1;
        repeat (3) cyc();
        vsync = 1'b0;
        cyc();
        cyc();
        rd_frame_start = 1'b1;
        cyc();
        rd_frame_start = 1'b0;
        chk("coin_rd_bank", 32'(rd_bank), 32'd1);
        chk("coin_pending", 32'(frame_pending), 32'd0);
        chk("coin_drop", 32'(drop_cnt), 32'(exp_drop));
        repeat (2) cyc();
        wr(7, 16'h7777, 1'b1, 1'b0, "coin_wr");

        // Truncated frame restarts on the same bank; out-of-range write discarded
        for (int a = 0; a < 1000; a++) wr(a, a[15:0] ^ 16'hFFFF, 1'b1, 1'b0, "trunc");
        frame_start();
        chk("trunc_pending", 32'(frame_pending), 32'd0);
        chk("trunc_drop", 32'(drop_cnt), 32'(exp_drop));
        wr(0, 16'hC0DE, 1'b1, 1'b0, "trunc_restart");
        wr(76800, 16'hBEEF, 1'b0, 1'b0, "oob");
        wr(76799, 16'hCAFE, 1'b1, 1'b0, "trunc_last");
        chk("trunc_last_pending", 32'(frame_pending), 32'd1);

        // Reset asserted mid-frame at address 500
        handover();
        chk("ho3_rd_bank", 32'(rd_bank), 32'd0);
        frame_start();
        for (int a = 490; a < 500; a++) wr(a, a[15:0], 1'b1, 1'b1, "pre_rst");
        we    = 1'b1;
        wAddr = 17'd500;
        wData = 16'h01F4;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        we    = 1'b0;
        exp_drop = 0;
        chk_reset_outputs("midrst");
        wr(501, 16'h01F5, 1'b0, 1'b1, "post_rst_idle");
        frame_start();
        wr(0, 16'h0F0F, 1'b1, 1'b1, "post_rst_cap");

        // Saturation of the drop counter
        wr(76799, 16'hF00D, 1'b1, 1'b1, "sat_last");
        chk("sat_pending", 32'(frame_pending), 32'd1);
        for (int i = 0; i < 260; i++) begin
            frame_start();
            if (DROP_EN && exp_drop < 255) exp_drop++;
        end
        chk("sat_drop", 32'(drop_cnt), 32'(exp_drop));
        chk("sat_pending_held", 32'(frame_pending), 32'd1);
        chk("sat_rd_bank", 32'(rd_bank), 32'd0);
        wr(9, 16'h9999, 1'b0, 1'b1, "sat_skip_wr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
